// File: rtl/sdm_pkg.sv
// Shared definitions for the sigma-delta real-number model: parameter
// defaults, legal ranges and the real-valued clamp / quantizer helpers.
package sdm_pkg;

    localparam int ORDER_DEF     = 2;
    localparam int ORDER_MIN     = 1;
    localparam int ORDER_MAX     = 3;
    localparam int QBITS_DEF     = 1;
    localparam int QBITS_MIN     = 1;
    localparam int QBITS_MAX     = 4;
    localparam int OVL_LIMIT_DEF = 16;

    // Unsigned quantizer code wide enough for the largest quantizer.
    typedef logic [QBITS_MAX-1:0] sdm_code_t;

    // Symmetric saturation of x to [-lim, +lim].
    function automatic real sdm_clamp(input real x, input real lim);
        if (x > lim) begin
            return lim;
        end
        if (x < -lim) begin
            return -lim;
        end
        return x;
    endfunction

    // Mid-rise quantizer: returns the integer code and its DAC level.
    // Multi-bit codes round to nearest with ties going up.
    function automatic void sdm_quantize(input real x, input int qbits,
                                         output int code, output real level);
        int  steps;
        int  k;
        real xc;
        real t;
        if (qbits <= 1) begin
            code  = (x >= 0.0) ? 1 : 0;
            level = (x >= 0.0) ? 1.0 : -1.0;
        end else begin
            steps = (1 << qbits) - 1;
            xc    = sdm_clamp(x, 1.0);
            t     = (xc + 1.0) * real'(steps) / 2.0;
            k     = int'($floor(t + 0.5));
            if (k > steps) begin
                k = steps;
            end
            if (k < 0) begin
                k = 0;
            end
            code  = k;
            level = -1.0 + (2.0 * real'(k)) / real'(steps);
        end
    endfunction

endpackage

// File: rtl/sdm_quant.sv
// Combinational quantizer: real integrator value in, QBITS code and the
// matching real feedback level out.
module sdm_quant
    import sdm_pkg::*;
#(
    parameter int QBITS = QBITS_DEF
) (
    input  real              x,
    output logic [QBITS-1:0] code,
    output real              level
);

    int  code_int;
    real level_q;

    // Evaluate the shared quantizer function on the current input.
    always_comb begin
        code_int = 0;
        level_q  = 0.0;
        sdm_quantize(x, QBITS, code_int, level_q);
    end

    assign code  = QBITS'(code_int);
    assign level = level_q;

endmodule

// File: rtl/sdm_rnm_gen.sv
// CIFB sigma-delta modulator real-number model with integrator clipping,
// clip/overload monitor, clock enable and output-valid strobe.
module sdm_rnm_gen
    import sdm_pkg::*;
#(
    parameter int  ORDER     = ORDER_DEF,
    parameter int  QBITS     = QBITS_DEF,
    parameter real A_IN      = 0.125,
    parameter real C_INT     = 0.5,
    parameter real B_FB      = 0.125,
    parameter real ICLIP     = 4.0,
    parameter int  OVL_LIMIT = OVL_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  real              analog_in,
    input  logic             clr_ovl,
    output logic [QBITS-1:0] dout,
    output logic             dout_valid,
    output logic             clip,
    output logic             overload
);

    if (ORDER < ORDER_MIN || ORDER > ORDER_MAX) begin : g_bad_order
        $fatal(1, "sdm_rnm_gen: ORDER must be in 1..3");
    end
    if (QBITS < QBITS_MIN || QBITS > QBITS_MAX) begin : g_bad_qbits
        $fatal(1, "sdm_rnm_gen: QBITS must be in 1..4");
    end

    localparam int                CNT_W   = $clog2(OVL_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_LIM = CNT_W'(OVL_LIMIT);

    real              x      [ORDER];
    real              x_next [ORDER];
    real              y_prev;
    logic             clip_next;
    logic [QBITS-1:0] code_new;
    real              level_new;
    logic [CNT_W-1:0] ovl_cnt;
    logic [CNT_W-1:0] cnt_next;

    // Quantizer sees the last integrator as it stands before the edge.
    sdm_quant #(
        .QBITS (QBITS)
    ) u_quant (
        .x     (x[ORDER-1]),
        .code  (code_new),
        .level (level_new)
    );

    // Integrator chain update; each stage feeds the already-clamped
    // output of the previous stage forward, feedback uses y_prev.
    always_comb begin : p_integ
        real prev;
        real raw;
        prev      = 0.0;
        raw       = 0.0;
        clip_next = 1'b0;
        for (int k = 0; k < ORDER; k++) begin
            x_next[k] = 0.0;
        end
        for (int k = 0; k < ORDER; k++) begin
            if (k == 0) begin
                raw = (x[0] + A_IN * analog_in) - B_FB * y_prev;
            end else begin
                raw = (x[k] + C_INT * prev) - B_FB * y_prev;
            end
            x_next[k] = sdm_clamp(raw, ICLIP);
            if (x_next[k] != raw) begin
                clip_next = 1'b1;
            end
            prev = x_next[k];
        end
    end

    // Consecutive-clip counter: saturates at the limit, cleared by a clean edge.
    always_comb begin
        cnt_next = ovl_cnt;
        if (en) begin
            if (clip_next) begin
                cnt_next = (ovl_cnt == CNT_LIM) ? ovl_cnt : ovl_cnt + 1'b1;
            end else begin
                cnt_next = '0;
            end
        end
    end

    // Loop state and code output advance only on enabled edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < ORDER; k++) begin
                x[k] <= 0.0;
            end
            y_prev     <= 0.0;
            dout       <= '0;
            dout_valid <= 1'b0;
            clip       <= 1'b0;
        end else begin
            dout_valid <= en;
            if (en) begin
                for (int k = 0; k < ORDER; k++) begin
                    x[k] <= x_next[k];
                end
                y_prev <= level_new;
                dout   <= code_new;
                clip   <= clip_next;
            end
        end
    end

    // Overload monitor; clr_ovl wins over any clip on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovl_cnt  <= '0;
            overload <= 1'b0;
        end else if (clr_ovl) begin
            ovl_cnt  <= '0;
            overload <= 1'b0;
        end else begin
            ovl_cnt <= cnt_next;
            if (cnt_next == CNT_LIM) begin
                overload <= 1'b1;
            end
        end
    end

endmodule
